// File: rtl/deserializer.sv
// Serial-to-parallel converter: collects MSB-first bits into a left-aligned word,
// flushing a partial word after GAP_TIMEOUT consecutive idle cycles mid-word.
module deserializer #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned GAP_TIMEOUT = 4
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic                       data_i,
    input  logic                       data_val_i,
    output logic [WIDTH-1:0]           deser_data_o,
    output logic [$clog2(WIDTH)-1:0]   deser_mod_o,
    output logic                       deser_data_val_o,
    output logic                       busy_o
);

    localparam int unsigned MOD_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned GAP_W = 8;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [MOD_W-1:0]   mod_q, mod_d;
    logic               val_q, val_d;
    logic               busy_q, busy_d;
    logic [MOD_W-1:0]   idx_c;
    logic [WIDTH-1:0]   word_c;

    // Bit position of the next incoming bit (only meaningful while collecting)
    assign idx_c = MOD_W'(WIDTH - 1) - MOD_W'(cnt_q);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        data_d  = data_q;
        mod_d   = mod_q;
        val_d   = 1'b0;
        word_c  = sreg_q;
        word_c[idx_c] = data_i;

        unique case (state_q)
            IDLE: begin
                // Fresh word: clear the register so a later flush has zero LSBs
                if (data_val_i) begin
                    sreg_d            = '0;
                    sreg_d[WIDTH-1]   = data_i;
                    cnt_d             = CNT_W'(1);
                    gap_d             = '0;
                    state_d           = COLLECT;
                end
            end
            COLLECT: begin
                if (data_val_i) begin
                    gap_d  = '0;
                    sreg_d = word_c;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        data_d  = word_c;
                        mod_d   = '0;
                        val_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (gap_q == GAP_W'(GAP_TIMEOUT - 1)) begin
                    // Idle run has hit the timeout: emit what we have
                    data_d  = sreg_q;
                    mod_d   = MOD_W'(cnt_q);
                    val_d   = 1'b1;
                    cnt_d   = '0;
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
        endcase

        busy_d = (state_d == COLLECT);
    end

    assign deser_data_o     = data_q;
    assign deser_mod_o      = mod_q;
    assign deser_data_val_o = val_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for the deserializer (WIDTH=16, GAP_TIMEOUT=4).
module tb_deserializer;

    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic        data_i;
    logic        data_val_i;
    logic [15:0] deser_data_o;
    logic [3:0]  deser_mod_o;
    logic        deser_data_val_o;
    logic        busy_o;

    int n_assert = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    logic prev_val = 1'b0;
    logic dbl_seen = 1'b0;
    int base;

    deserializer #(.WIDTH(16), .GAP_TIMEOUT(4)) dut (
        .clk_i            (clk_i),
        .arst_n_i         (arst_n_i),
        .data_i           (data_i),
        .data_val_i       (data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_mod_o      (deser_mod_o),
        .deser_data_val_o (deser_data_val_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Count output pulses and flag any back-to-back valid cycles
    always @(negedge clk_i) begin
        if (deser_data_val_o) pulse_cnt <= pulse_cnt + 1;
        dbl_seen <= dbl_seen | (deser_data_val_o & prev_val);
        prev_val <= deser_data_val_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic b);
        data_val_i = v;
        data_i     = b;
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) step(1'b1, w[i]);
    endtask

    initial begin
        logic [15:0] w;
        arst_n_i   = 1'b0;
        data_i     = 1'b0;
        data_val_i = 1'b0;
        #3;
        chk("rst_data", 32'(deser_data_o), 32'h0);
        chk("rst_mod",  32'(deser_mod_o), 32'h0);
        chk("rst_val",  32'(deser_data_val_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        repeat (2) @(posedge clk_i);
        #1 arst_n_i = 1'b1;

        // Idle input in IDLE: nothing happens
        repeat (6) step(1'b0, 1'b1);
        chk("idle_busy",   32'(busy_o), 32'h0);
        chk("idle_pulses", 32'(pulse_cnt), 32'd0);

        // Full word F0F0
        w = 16'hF0F0;
        step(1'b1, w[15]);
        chk("a_busy_first", 32'(busy_o), 32'h1);
        for (int i = 14; i >= 0; i--) step(1'b1, w[i]);
        chk("a_val",  32'(deser_data_val_o), 32'h1);
        chk("a_data", 32'(deser_data_o), 32'hF0F0);
        chk("a_mod",  32'(deser_mod_o), 32'h0);
        chk("a_busy", 32'(busy_o), 32'h0);
        step(1'b0, 1'b0);
        chk("a_val_drop", 32'(deser_data_val_o), 32'h0);
        chk("a_hold",     32'(deser_data_o), 32'hF0F0);
        repeat (6) step(1'b0, 1'b0);
        chk("a_pulses", 32'(pulse_cnt), 32'd1);

        // Back-to-back A5A5, 1234
        base = pulse_cnt;
        send_word(16'hA5A5);
        chk("b_val1",  32'(deser_data_val_o), 32'h1);
        chk("b_data1", 32'(deser_data_o), 32'hA5A5);
        w = 16'h1234;
        step(1'b1, w[15]);
        chk("b_val_gap", 32'(deser_data_val_o), 32'h0);
        chk("b_busy2",   32'(busy_o), 32'h1);
        for (int i = 14; i >= 1; i--) step(1'b1, w[i]);
        chk("b_val_early", 32'(deser_data_val_o), 32'h0);
        step(1'b1, w[0]);
        chk("b_val2",  32'(deser_data_val_o), 32'h1);
        chk("b_data2", 32'(deser_data_o), 32'h1234);
        chk("b_mod2",  32'(deser_mod_o), 32'h0);
        step(1'b0, 1'b0);
        chk("b_pulses", 32'(pulse_cnt - base), 32'd2);

        // Partial word 1,0,1,1,0 then timeout flush
        base = pulse_cnt;
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        step(1'b1, 1'b1); step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        chk("c_no_early", 32'(deser_data_val_o), 32'h0);
        chk("c_busy",     32'(busy_o), 32'h1);
        step(1'b0, 1'b0);
        chk("c_val",  32'(deser_data_val_o), 32'h1);
        chk("c_data", 32'(deser_data_o), 32'hB000);
        chk("c_mod",  32'(deser_mod_o), 32'd5);
        chk("c_busy_after", 32'(busy_o), 32'h0);
        repeat (6) step(1'b0, 1'b0);
        chk("c_pulses", 32'(pulse_cnt - base), 32'd1);

        // F0F0 with a 3-cycle gap after bit 8: no flush
        base = pulse_cnt;
        w = 16'hF0F0;
        for (int i = 15; i >= 8; i--) step(1'b1, w[i]);
        repeat (3) step(1'b0, 1'b0);
        chk("d_busy_gap", 32'(busy_o), 32'h1);
        for (int i = 7; i >= 0; i--) step(1'b1, w[i]);
        chk("d_val",  32'(deser_data_val_o), 32'h1);
        chk("d_data", 32'(deser_data_o), 32'hF0F0);
        chk("d_mod",  32'(deser_mod_o), 32'h0);
        step(1'b0, 1'b0);
        chk("d_pulses", 32'(pulse_cnt - base), 32'd1);

        // Reset between edges after 7 bits, then 00FF
        base = pulse_cnt;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
        data_val_i = 1'b0;
        #2 arst_n_i = 1'b0;
        #1;
        chk("e_rst_data", 32'(deser_data_o), 32'h0);
        chk("e_rst_mod",  32'(deser_mod_o), 32'h0);
        chk("e_rst_busy", 32'(busy_o), 32'h0);
        #2 arst_n_i = 1'b1;
        @(posedge clk_i); #1;
        repeat (6) step(1'b0, 1'b0);
        chk("e_no_pulse", 32'(pulse_cnt - base), 32'd0);
        send_word(16'h00FF);
        chk("e_val",  32'(deser_data_val_o), 32'h1);
        chk("e_data", 32'(deser_data_o), 32'h00FF);
        chk("e_mod",  32'(deser_mod_o), 32'h0);
        step(1'b0, 1'b0);
        chk("e_pulses", 32'(pulse_cnt - base), 32'd1);

        chk("no_double_pulse", 32'(dbl_seen), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout n_assert=%0d", n_assert);
        $fatal(1, "bench did not finish");
    end

endmodule
